// File: rtl/snake_game_core.sv
// Snake game logic for the 64x48-cell VGA renderer: body, item, length, step timer, win/lose.
// Optional SNAKE_ITEM_AVOID_BODY_EN: item placement also rejects cells under the body.
module snake_game_core #(
    parameter int          MAX_SIZE  = 100,
    parameter int          INIT_SIZE = 3,
    parameter int          TICK_DIV  = 5000000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_start,
    input  logic                  i_up,
    input  logic                  i_down,
    input  logic                  i_left,
    input  logic                  i_right,
    output logic [MAX_SIZE*6-1:0] o_worm_x,
    output logic [MAX_SIZE*6-1:0] o_worm_y,
    output logic [5:0]            o_item_x,
    output logic [5:0]            o_item_y,
    output logic [11:0]           o_size,
    output logic                  o_game_over,
    output logic                  o_busy
);
    localparam int IDX_W = (MAX_SIZE > 1) ? $clog2(MAX_SIZE) : 1;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_CHECK, S_UPDATE, S_PLACE, S_OVER} state_t;
    typedef enum logic [1:0] {D_UP = 2'd0, D_DOWN = 2'd1, D_LEFT = 2'd2, D_RIGHT = 2'd3} dir_t;
    typedef logic [MAX_SIZE-1:0][5:0] seg_t;

    function automatic seg_t init_x();
        seg_t s;
        s = '0;
        for (int k = 0; k < INIT_SIZE; k++) s[k] = 6'(32 - k);
        return s;
    endfunction

    function automatic seg_t init_y();
        seg_t s;
        s = '0;
        for (int k = 0; k < INIT_SIZE; k++) s[k] = 6'd24;
        return s;
    endfunction

    function automatic logic playable(input logic [5:0] x, input logic [5:0] y);
        return (x >= 6'd1) && (x <= 6'd62) && (y >= 6'd1) && (y <= 6'd46);
    endfunction

    localparam seg_t INIT_X = init_x();
    localparam seg_t INIT_Y = init_y();

    state_t             state_q, state_d;
    seg_t               seg_x_q, seg_x_d, seg_y_q, seg_y_d;
    logic [5:0]         item_x_q, item_x_d, item_y_q, item_y_d;
    logic [11:0]        size_q, size_d;
    dir_t               dir_q, dir_d, pend_q, pend_d;
    logic [31:0]        tick_q, tick_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [5:0]         nh_x_q, nh_x_d, nh_y_q, nh_y_d;
    logic               eat_q, eat_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               go_q, busy_q;
`ifdef SNAKE_ITEM_AVOID_BODY_EN
    logic [5:0]         cand_x_q, cand_x_d, cand_y_q, cand_y_d;
    logic               cand_vld_q, cand_vld_d;
`endif

    logic        req_vld;
    dir_t        req_dir;
    logic [5:0]  nh_x, nh_y;
    logic [5:0]  cx, cy_raw, cy;
    logic [15:0] lfsr_step;
    logic [11:0] limit, idx_ext;

    always_comb begin
        req_vld = i_up | i_down | i_left | i_right;
        req_dir = D_RIGHT;
        if (i_up)        req_dir = D_UP;
        else if (i_down) req_dir = D_DOWN;
        else if (i_left) req_dir = D_LEFT;
    end

    // Next head follows the pending direction; 6-bit wrap always lands on a wall cell.
    always_comb begin
        nh_x = seg_x_q[0];
        nh_y = seg_y_q[0];
        case (pend_q)
            D_UP:    nh_y = seg_y_q[0] - 6'd1;
            D_DOWN:  nh_y = seg_y_q[0] + 6'd1;
            D_LEFT:  nh_x = seg_x_q[0] - 6'd1;
            default: nh_x = seg_x_q[0] + 6'd1;
        endcase
    end

    always_comb begin
        lfsr_step = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        cx        = lfsr_q[5:0];
        cy_raw    = lfsr_q[11:6];
        cy        = (cy_raw >= 6'd48) ? cy_raw - 6'd48 : cy_raw;
        // A tail that vacates this step is not an obstacle unless we are growing.
        limit     = eat_q ? size_q - 12'd1 : size_q - 12'd2;
        idx_ext   = 12'(idx_q);
    end

    always_comb begin
        state_d  = state_q;
        seg_x_d  = seg_x_q;
        seg_y_d  = seg_y_q;
        item_x_d = item_x_q;
        item_y_d = item_y_q;
        size_d   = size_q;
        dir_d    = dir_q;
        pend_d   = pend_q;
        tick_d   = tick_q;
        lfsr_d   = lfsr_q;
        nh_x_d   = nh_x_q;
        nh_y_d   = nh_y_q;
        eat_d    = eat_q;
        idx_d    = idx_q;
`ifdef SNAKE_ITEM_AVOID_BODY_EN
        cand_x_d   = cand_x_q;
        cand_y_d   = cand_y_q;
        cand_vld_d = cand_vld_q;
`endif

        if (state_q != S_OVER && req_vld && (req_dir != (dir_q ^ 2'b01)))
            pend_d = req_dir;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_RUN;
                    tick_d  = '0;
                end
            end
            S_RUN: begin
                if (tick_q == 32'(TICK_DIV - 1)) begin
                    tick_d  = '0;
                    state_d = S_CHECK;
                    dir_d   = pend_q;
                    nh_x_d  = nh_x;
                    nh_y_d  = nh_y;
                    eat_d   = (nh_x == item_x_q) && (nh_y == item_y_q);
                    idx_d   = '0;
                end else begin
                    tick_d = tick_q + 32'd1;
                end
            end
            S_CHECK: begin
                if (!playable(nh_x_q, nh_y_q))
                    state_d = S_OVER;
                else if (seg_x_q[idx_q] == nh_x_q && seg_y_q[idx_q] == nh_y_q)
                    state_d = S_OVER;
                else if (idx_ext == limit)
                    state_d = S_UPDATE;
                else
                    idx_d = idx_q + 1'b1;
            end
            S_UPDATE: begin
                seg_x_d = {seg_x_q[MAX_SIZE-2:0], nh_x_q};
                seg_y_d = {seg_y_q[MAX_SIZE-2:0], nh_y_q};
                if (eat_q && size_q < 12'(MAX_SIZE)) size_d = size_q + 12'd1;
                state_d = eat_q ? S_PLACE : S_RUN;
                idx_d   = '0;
`ifdef SNAKE_ITEM_AVOID_BODY_EN
                cand_vld_d = 1'b0;
`endif
            end
            S_PLACE: begin
                lfsr_d = lfsr_step;
`ifdef SNAKE_ITEM_AVOID_BODY_EN
                if (!cand_vld_q) begin
                    if (playable(cx, cy)) begin
                        cand_x_d   = cx;
                        cand_y_d   = cy;
                        cand_vld_d = 1'b1;
                        idx_d      = '0;
                    end
                end else if (seg_x_q[idx_q] == cand_x_q && seg_y_q[idx_q] == cand_y_q) begin
                    cand_vld_d = 1'b0;
                end else if (idx_ext == size_q - 12'd1) begin
                    item_x_d   = cand_x_q;
                    item_y_d   = cand_y_q;
                    cand_vld_d = 1'b0;
                    state_d    = S_RUN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
`else
                if (playable(cx, cy)) begin
                    item_x_d = cx;
                    item_y_d = cy;
                    state_d  = S_RUN;
                end
`endif
            end
            S_OVER: begin
                // Restart keeps the LFSR so successive games see different items.
                if (i_start) begin
                    seg_x_d  = INIT_X;
                    seg_y_d  = INIT_Y;
                    item_x_d = 6'd48;
                    item_y_d = 6'd24;
                    size_d   = 12'(INIT_SIZE);
                    dir_d    = D_RIGHT;
                    pend_d   = D_RIGHT;
                    tick_d   = '0;
                    state_d  = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q  <= S_IDLE;
            seg_x_q  <= INIT_X;
            seg_y_q  <= INIT_Y;
            item_x_q <= 6'd48;
            item_y_q <= 6'd24;
            size_q   <= 12'(INIT_SIZE);
            dir_q    <= D_RIGHT;
            pend_q   <= D_RIGHT;
            tick_q   <= '0;
            lfsr_q   <= LFSR_SEED;
            nh_x_q   <= '0;
            nh_y_q   <= '0;
            eat_q    <= 1'b0;
            idx_q    <= '0;
            go_q     <= 1'b0;
            busy_q   <= 1'b0;
`ifdef SNAKE_ITEM_AVOID_BODY_EN
            cand_x_q   <= '0;
            cand_y_q   <= '0;
            cand_vld_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            seg_x_q  <= seg_x_d;
            seg_y_q  <= seg_y_d;
            item_x_q <= item_x_d;
            item_y_q <= item_y_d;
            size_q   <= size_d;
            dir_q    <= dir_d;
            pend_q   <= pend_d;
            tick_q   <= tick_d;
            lfsr_q   <= lfsr_d;
            nh_x_q   <= nh_x_d;
            nh_y_q   <= nh_y_d;
            eat_q    <= eat_d;
            idx_q    <= idx_d;
            go_q     <= (state_d == S_OVER);
            busy_q   <= (state_d == S_CHECK) || (state_d == S_UPDATE) || (state_d == S_PLACE);
`ifdef SNAKE_ITEM_AVOID_BODY_EN
            cand_x_q   <= cand_x_d;
            cand_y_q   <= cand_y_d;
            cand_vld_q <= cand_vld_d;
`endif
        end
    end

    assign o_worm_x    = seg_x_q;
    assign o_worm_y    = seg_y_q;
    assign o_item_x    = item_x_q;
    assign o_item_y    = item_y_q;
    assign o_size      = size_q;
    assign o_game_over = go_q;
    assign o_busy      = busy_q;
endmodule

// File: tb/tb_snake_game_core.sv
// Directed scoreboard bench for snake_game_core: two instances (INIT_SIZE 3 and 5), TICK_DIV 4.
module tb_snake_game_core;
    localparam int MS = 16;
    localparam int B_START = 0, B_UP = 1, B_DOWN = 2, B_LEFT = 3, B_RIGHT = 4, NONE = -1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] a_in = '0, b_in = '0;
    logic [MS*6-1:0] a_wx, a_wy, b_wx, b_wy;
    logic [5:0]  a_ix, a_iy, b_ix, b_iy;
    logic [11:0] a_size, b_size;
    logic        a_go, a_busy, b_go, b_busy;

    int cyc = 0;
    int vectors = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    snake_game_core #(.MAX_SIZE(MS), .INIT_SIZE(3), .TICK_DIV(4), .LFSR_SEED(16'hACE1)) dut_a (
        .i_Clk(clk), .i_Rst(rst), .i_start(a_in[0]), .i_up(a_in[1]), .i_down(a_in[2]),
        .i_left(a_in[3]), .i_right(a_in[4]), .o_worm_x(a_wx), .o_worm_y(a_wy),
        .o_item_x(a_ix), .o_item_y(a_iy), .o_size(a_size), .o_game_over(a_go), .o_busy(a_busy));

    snake_game_core #(.MAX_SIZE(MS), .INIT_SIZE(5), .TICK_DIV(4), .LFSR_SEED(16'hACE1)) dut_b (
        .i_Clk(clk), .i_Rst(rst), .i_start(b_in[0]), .i_up(b_in[1]), .i_down(b_in[2]),
        .i_left(b_in[3]), .i_right(b_in[4]), .o_worm_x(b_wx), .o_worm_y(b_wy),
        .o_item_x(b_ix), .o_item_y(b_iy), .o_size(b_size), .o_game_over(b_go), .o_busy(b_busy));

    typedef struct { string tag; int u; int sel; int k; int exp; } exp_t;
    exp_t sb[$];

    // sel: 0 seg x, 1 seg y, 2 item x, 3 item y, 4 size, 5 game_over, 6 busy,
    //      7 item playable, 8 item moved off (48,24)
    function automatic int obs(input int u, input int sel, input int k);
        logic [MS*6-1:0] wx, wy;
        logic [5:0] ix, iy;
        logic [11:0] sz;
        logic go, bz;
        if (u == 0) begin wx = a_wx; wy = a_wy; ix = a_ix; iy = a_iy; sz = a_size; go = a_go; bz = a_busy; end
        else        begin wx = b_wx; wy = b_wy; ix = b_ix; iy = b_iy; sz = b_size; go = b_go; bz = b_busy; end
        case (sel)
            0: return int'(wx[k*6 +: 6]);
            1: return int'(wy[k*6 +: 6]);
            2: return int'(ix);
            3: return int'(iy);
            4: return int'(sz);
            5: return int'(go);
            6: return int'(bz);
            7: return int'(ix >= 6'd1 && ix <= 6'd62 && iy >= 6'd1 && iy <= 6'd46);
            default: return int'(!(ix == 6'd48 && iy == 6'd24));
        endcase
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input int u, input int sel, input int k, input int exp);
        exp_t e;
        e.tag = tag; e.u = u; e.sel = sel; e.k = k; e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic exp_seg(input int u, input int k, input int x, input int y);
        push($sformatf("u%0d_seg%0d_x", u, k), u, 0, k, x);
        push($sformatf("u%0d_seg%0d_y", u, k), u, 1, k, y);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, obs(e.u, e.sel, e.k), e.exp);
        end
    endtask

    task automatic pulse(input int u, input int b);
        @(negedge clk);
        if (u == 0) a_in[b] = 1'b1; else b_in[b] = 1'b1;
        @(negedge clk);
        a_in = '0;
        b_in = '0;
    endtask

    // Returns at the first negedge where busy has dropped after one game step.
    task automatic wait_step(input int u, output int t);
        int n;
        n = 0;
        while (obs(u, 6, 0) !== 1 && n < 200) begin @(negedge clk); n++; end
        while (obs(u, 6, 0) !== 0 && n < 400) begin @(negedge clk); n++; end
        chk($sformatf("u%0d_step_bound", u), int'(n < 400), 1);
        t = cyc;
    endtask

    task automatic move(input int u, input int b, output int t);
        if (b >= 0) pulse(u, b);
        wait_step(u, t);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        int t0, t1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        exp_seg(0, 0, 32, 24); exp_seg(0, 1, 31, 24); exp_seg(0, 2, 30, 24);
        push("a_rst_size", 0, 4, 0, 3);
        push("a_rst_item_x", 0, 2, 0, 48); push("a_rst_item_y", 0, 3, 0, 24);
        push("a_rst_go", 0, 5, 0, 0); push("a_rst_busy", 0, 6, 0, 0);
        exp_seg(1, 0, 32, 24); exp_seg(1, 3, 29, 24); exp_seg(1, 4, 28, 24);
        push("b_rst_size", 1, 4, 0, 5);
        drain();

        repeat (10) @(negedge clk);
        exp_seg(0, 0, 32, 24); exp_seg(0, 2, 30, 24);
        push("a_idle_busy", 0, 6, 0, 0);
        drain();

        // First step after start, then a reversal request that must be ignored.
        move(0, B_START, t0);
        exp_seg(0, 0, 33, 24); exp_seg(0, 1, 32, 24); exp_seg(0, 2, 31, 24);
        push("a_step1_size", 0, 4, 0, 3);
        drain();

        move(0, B_LEFT, t1);
        chk("a_step_spacing", t1 - t0, 7);
        exp_seg(0, 0, 34, 24); exp_seg(0, 2, 32, 24);
        drain();

        move(0, B_UP, t0);    exp_seg(0, 0, 34, 23); exp_seg(0, 1, 34, 24); drain();
        move(0, B_RIGHT, t0); exp_seg(0, 0, 35, 23); drain();
        move(0, B_DOWN, t0);  exp_seg(0, 0, 35, 24); drain();
        move(0, B_RIGHT, t0); exp_seg(0, 0, 36, 24); drain();
        for (int x = 37; x <= 47; x++) begin
            move(0, NONE, t0);
            exp_seg(0, 0, x, 24);
            drain();
        end

        // Eat the item at (48,24): grow without dropping the tail, new item elsewhere.
        move(0, NONE, t0);
        push("a_eat_size", 0, 4, 0, 4);
        exp_seg(0, 0, 48, 24); exp_seg(0, 1, 47, 24); exp_seg(0, 2, 46, 24); exp_seg(0, 3, 45, 24);
        push("a_item_playable", 0, 7, 0, 1);
        push("a_item_moved", 0, 8, 0, 1);
        push("a_eat_go", 0, 5, 0, 0);
        drain();

        // Tight square: the head twice enters the cell the tail is leaving.
        move(0, B_UP, t0);   exp_seg(0, 0, 48, 23); drain();
        move(0, B_LEFT, t0); exp_seg(0, 0, 47, 23); drain();
        move(0, B_DOWN, t0);
        exp_seg(0, 0, 47, 24); exp_seg(0, 3, 48, 24);
        push("a_tail_chase1_go", 0, 5, 0, 0);
        drain();
        move(0, B_RIGHT, t0);
        exp_seg(0, 0, 48, 24); exp_seg(0, 3, 48, 23);
        push("a_tail_chase2_go", 0, 5, 0, 0); push("a_tail_chase_size", 0, 4, 0, 4);
        drain();

        for (int x = 49; x <= 62; x++) begin
            move(0, NONE, t0);
            exp_seg(0, 0, x, 24);
            drain();
        end

        // Next step targets the x=63 wall.
        move(0, NONE, t0);
        push("a_wall_go", 0, 5, 0, 1); push("a_wall_busy", 0, 6, 0, 0);
        exp_seg(0, 0, 62, 24); push("a_wall_size", 0, 4, 0, 4);
        drain();
        repeat (20) @(negedge clk);
        pulse(0, B_UP);
        exp_seg(0, 0, 62, 24); exp_seg(0, 1, 61, 24);
        push("a_over_hold_go", 0, 5, 0, 1);
        drain();

        pulse(0, B_START);
        exp_seg(0, 0, 32, 24); exp_seg(0, 1, 31, 24); exp_seg(0, 2, 30, 24);
        push("a_restart_size", 0, 4, 0, 3);
        push("a_restart_item_x", 0, 2, 0, 48); push("a_restart_item_y", 0, 3, 0, 24);
        push("a_restart_go", 0, 5, 0, 0);
        drain();
        move(0, NONE, t0);
        exp_seg(0, 0, 33, 24);
        drain();
        move(0, B_START, t0);
        exp_seg(0, 0, 34, 24); push("a_run_start_size", 0, 4, 0, 3);
        drain();

        // INIT_SIZE 5: up, left, down runs the head into segment 3.
        move(1, B_START, t0);
        exp_seg(1, 0, 33, 24); drain();
        move(1, B_UP, t0);   exp_seg(1, 0, 33, 23); drain();
        move(1, B_LEFT, t0); exp_seg(1, 0, 32, 23); drain();
        move(1, B_DOWN, t0);
        push("b_self_go", 1, 5, 0, 1);
        exp_seg(1, 0, 32, 23); exp_seg(1, 1, 33, 23);
        push("b_self_size", 1, 4, 0, 5);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
